// File: rtl/dbus_mem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbus_mem_responder_if                                            |
// | Request/response bundle between the data-bus aligner and memory. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dbus_mem_responder_if;
    logic        req_valid;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic        resp_addr_ok;
    logic        resp_data_ok;
    logic [63:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/dbus_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbus_mem_responder                                               |
// | Fixed-latency data memory with request checking.                 |
// | Optional counters: DBUS_RESP_STATS_EN. Revision: 1.0             |
// +------------------------------------------------------------------+
module dbus_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_mem_responder_if.slave  bus
`ifdef DBUS_RESP_STATS_EN
    ,
    output logic [31:0]          stat_reads,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_errs
`endif
);

    localparam int unsigned c_aw       = $clog2(DEPTH);
    localparam logic [63:0] c_span     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        w_latch;
    logic [63:0] r_addr, r_data;
    logic [2:0]  r_size;
    logic [7:0]  r_strobe;

    logic [63:0] r_mem [DEPTH];

    logic [63:0] w_addr, w_data, w_off;
    logic [2:0]  w_size;
    logic [7:0]  w_strobe, w_mask;
    logic [15:0] w_shifted;
    logic        w_size_err, w_align_err, w_range_err, w_strobe_err;
    logic        w_err, w_is_write, w_enter_resp;
    logic [c_aw-1:0] w_idx;

    // With LATENCY=1 the request goes straight from IDLE to RESP, so the
    // checks must see the live request fields rather than the latch.
    always_comb begin
        w_addr   = (r_state == S_IDLE) ? bus.req_addr   : r_addr;
        w_size   = (r_state == S_IDLE) ? bus.req_size   : r_size;
        w_strobe = (r_state == S_IDLE) ? bus.req_strobe : r_strobe;
        w_data   = (r_state == S_IDLE) ? bus.req_data   : r_data;
    end

    always_comb begin
        w_mask      = 8'h00;
        w_size_err  = 1'b0;
        w_align_err = 1'b0;
        case (w_size)
            3'd0: w_mask = 8'h01;
            3'd1: begin w_mask = 8'h03; w_align_err = w_addr[0];     end
            3'd2: begin w_mask = 8'h0F; w_align_err = |w_addr[1:0]; end
            3'd3: begin w_mask = 8'hFF; w_align_err = |w_addr[2:0]; end
            default: w_size_err = 1'b1;
        endcase
        w_off        = w_addr - BASE_ADDR;
        w_range_err  = (w_addr < BASE_ADDR) || (w_off >= c_span);
        w_shifted    = {8'h00, w_mask} << w_addr[2:0];
        w_is_write   = |w_strobe;
        w_strobe_err = w_is_write && ({8'h00, w_strobe} != w_shifted);
        w_err        = w_size_err || w_align_err || w_range_err || w_strobe_err;
        w_idx        = w_off[c_aw+2:3];
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_latch      = 1'b1;
                    w_cnt_next   = c_cnt_init;
                    w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.req_valid) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_enter_resp = (w_state_next == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 64'd0;
            r_size   <= 3'd0;
            r_strobe <= 8'd0;
            r_data   <= 64'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_addr   <= bus.req_addr;
                r_size   <= bus.req_size;
                r_strobe <= bus.req_strobe;
                r_data   <= bus.req_data;
            end
        end
    end

    // Outputs are registered on the edge entering RESP so they are high
    // exactly during the RESP cycle; the write commits on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_addr_ok <= 1'b0;
            bus.resp_data_ok <= 1'b0;
            bus.resp_err     <= 1'b0;
            bus.resp_data    <= 64'd0;
        end else begin
            bus.resp_addr_ok <= w_enter_resp;
            bus.resp_data_ok <= w_enter_resp;
            bus.resp_err     <= w_enter_resp && w_err;
            bus.resp_data    <= (w_enter_resp && !w_err && !w_is_write) ? r_mem[w_idx] : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_is_write && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (w_strobe[k]) r_mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
            end
        end
    end

`ifdef DBUS_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads  <= 32'd0;
            stat_writes <= 32'd0;
            stat_errs   <= 32'd0;
        end else if (w_enter_resp) begin
            if (w_err) begin
                if (stat_errs != 32'hFFFF_FFFF) stat_errs <= stat_errs + 32'd1;
            end else if (w_is_write) begin
                if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
            end else begin
                if (stat_reads != 32'hFFFF_FFFF) stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbus_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dbus_mem_responder                                            |
// | Scoreboard bench: LATENCY=2 and LATENCY=4 instances. Revision 1.0|
// +------------------------------------------------------------------+
module tb_dbus_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_mem_responder_if b2 ();
    dbus_mem_responder_if b4 ();

`ifdef DBUS_RESP_STATS_EN
    logic [31:0] s2_rd, s2_wr, s2_er, s4_rd, s4_wr, s4_er;
    int          m_rd = 0, m_wr = 0, m_er = 0;
`endif

    dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
`ifdef DBUS_RESP_STATS_EN
        , .stat_reads(s2_rd), .stat_writes(s2_wr), .stat_errs(s2_er)
`endif
    );

    dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) dut4 (
        .clk(clk), .reset(reset), .bus(b4)
`ifdef DBUS_RESP_STATS_EN
        , .stat_reads(s4_rd), .stat_writes(s4_wr), .stat_errs(s4_er)
`endif
    );

    typedef struct {
        logic        err;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        q2[$];
    exp_t        q4[$];
    logic [63:0] mdl [2][DEPTH];
    int          errors = 0;
    int          checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: request legality from plain arithmetic on size/offset.
    function automatic bit expect_err(logic [63:0] a, logic [2:0] s, logic [7:0] st);
        int nb, off, want;
        if (s > 3'd3) return 1'b1;
        if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8) return 1'b1;
        nb  = 1 << s;
        off = int'(a[2:0]);
        if (off % nb != 0) return 1'b1;
        want = ((1 << nb) - 1) << off;
        if (st != 8'd0 && int'(st) != want) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mon(int sel, logic dok, logic aok, logic err, logic [63:0] data);
        exp_t e;
        if (dok) begin
            if ((sel == 0 && q2.size() == 0) || (sel == 1 && q4.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_data_ok dut%0d: got 1 expected 0 (t=%0t)", sel, $time);
            end else begin
                e = (sel == 0) ? q2.pop_front() : q4.pop_front();
                check("addr_ok", 64'(aok), 64'd1);
                check("resp_err", 64'(err), 64'(e.err));
                check("resp_data", data, e.data);
                check("latency_cycle", 64'(cyc), 64'(e.due));
            end
        end else begin
            check("idle_outputs", {62'd0, aok, |data}, 64'd0);
        end
    endtask

    always @(negedge clk) if (mon_en) mon(0, b2.resp_data_ok, b2.resp_addr_ok, b2.resp_err, b2.resp_data);
    always @(negedge clk) if (mon_en) mon(1, b4.resp_data_ok, b4.resp_addr_ok, b4.resp_err, b4.resp_data);

    task automatic drive(int sel, logic v, logic [63:0] a, logic [2:0] s, logic [7:0] st, logic [63:0] d);
        if (sel == 0) begin
            b2.req_valid = v; b2.req_addr = a; b2.req_size = s; b2.req_strobe = st; b2.req_data = d;
        end else begin
            b4.req_valid = v; b4.req_addr = a; b4.req_size = s; b4.req_strobe = st; b4.req_data = d;
        end
    endtask

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 after RESP.
    task automatic issue(int sel, logic [63:0] a, logic [2:0] s, logic [7:0] st, logic [63:0] d);
        exp_t e;
        int   idx;
        bit   seen;
        e.err  = expect_err(a, s, st);
        e.data = 64'd0;
        e.due  = cyc + ((sel == 0) ? 2 : 4);
        if (!e.err) begin
            idx = int'((a - BASE) >> 3);
            if (st == 8'd0) e.data = mdl[sel][idx];
            else for (int k = 0; k < 8; k++) if (st[k]) mdl[sel][idx][8*k +: 8] = d[8*k +: 8];
        end
`ifdef DBUS_RESP_STATS_EN
        if (sel == 0) begin
            if (e.err) m_er++; else if (st != 8'd0) m_wr++; else m_rd++;
        end
`endif
        if (sel == 0) q2.push_back(e); else q4.push_back(e);
        drive(sel, 1'b1, a, s, st, d);
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clk);
            seen = (sel == 0) ? b2.resp_data_ok : b4.resp_data_ok;
        end
        check("data_ok_arrived", 64'(seen), 64'd1);
        if (!seen) begin
            if (sel == 0) void'(q2.pop_back()); else void'(q4.pop_back());
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, a, s, st, d);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, d;
        logic [2:0]  s;
        logic [7:0]  st;
        int          r, off, nb;
        bit          seen;

        reset = 1'b1;
        drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        drive(1, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_ok", 64'(b2.resp_data_ok), 64'd0);
        check("reset_addr_ok", 64'(b2.resp_addr_ok), 64'd0);
        check("reset_err", 64'(b2.resp_err), 64'd0);
        check("reset_data", b2.resp_data, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int w = 0; w < 8; w++) issue(0, BASE + 64'(w * 8), 3'd3, 8'hFF, {$urandom, $urandom});

        // Directed cases from the plan
        issue(0, BASE + 64'h10, 3'd3, 8'hFF, 64'h1122_3344_5566_7788);
        issue(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0);
        issue(0, BASE + 64'h13, 3'd0, 8'h08, 64'h0000_0000_AB00_0000);
        issue(0, BASE + 64'h10, 3'd3, 8'h00, 64'd0);
        check("merged_word_model", mdl[0][2], 64'h1122_3344_AB66_7788);
        issue(0, BASE + 64'h02, 3'd2, 8'h00, 64'd0);
        issue(0, BASE + 64'h08, 3'd1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(0, BASE + 64'h08, 3'd3, 8'h00, 64'd0);
        issue(0, BASE - 64'd8, 3'd3, 8'h00, 64'd0);
        issue(0, BASE + 64'(DEPTH) * 64'd8, 3'd3, 8'h00, 64'd0);
        issue(0, BASE + 64'h18, 3'd2, 8'h00, 64'd0);
        idle(2);

        // Reset while a write sits in WAIT: no write, no completion
        drive(0, 1'b1, BASE + 64'h18, 3'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        @(negedge clk);
        check("rst_mid_data_ok", 64'(b2.resp_data_ok), 64'd0);
        check("rst_mid_addr_ok", 64'(b2.resp_addr_ok), 64'd0);
        check("rst_mid_err", 64'(b2.resp_err), 64'd0);
        check("rst_mid_data", b2.resp_data, 64'd0);
`ifdef DBUS_RESP_STATS_EN
        check("rst_stat_reads", 64'(s2_rd), 64'd0);
        m_rd = 0; m_wr = 0; m_er = 0;
`endif
        @(posedge clk);
        #1;
        issue(0, BASE + 64'h18, 3'd3, 8'h00, 64'd0);

        // Randomised traffic on the LATENCY=2 instance
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            a = BASE + 64'($urandom_range(0, 7) * 8);
            d = {$urandom, $urandom};
            if (r < 6) begin
                s   = 3'($urandom_range(0, 3));
                nb  = 1 << s;
                off = ($urandom_range(0, 7) / nb) * nb;
                a   = a + 64'(off);
                st  = ($urandom_range(0, 1) == 1) ? 8'(((1 << nb) - 1) << off) : 8'h00;
            end else if (r < 8) begin
                s  = 3'($urandom_range(0, 7));
                a  = a + 64'($urandom_range(0, 7));
                st = 8'($urandom_range(0, 255));
            end else begin
                a  = ($urandom_range(0, 1) == 1) ? BASE - 64'($urandom_range(1, 4) * 8)
                                                 : BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 3) * 8);
                s  = 3'd3;
                st = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            end
            issue(0, a, s, st, d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // LATENCY=4 instance: normal traffic, then an aborted write
        issue(1, BASE, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF);
        issue(1, BASE, 3'd3, 8'h00, 64'd0);
        drive(1, 1'b1, BASE, 3'd3, 8'hFF, 64'hFFFF_0000_FFFF_0000);
        idle(1);
        idle(1);
        drive(1, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | b4.resp_data_ok;
        end
        check("abort_no_data_ok", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        issue(1, BASE, 3'd3, 8'h00, 64'd0);
        issue(1, BASE + 64'h6, 3'd1, 8'hC0, 64'h5A5A_0000_0000_0000);
        issue(1, BASE, 3'd3, 8'h00, 64'd0);
        idle(2);

`ifdef DBUS_RESP_STATS_EN
        check("stat_reads", 64'(s2_rd), 64'(m_rd));
        check("stat_writes", 64'(s2_wr), 64'(m_wr));
        check("stat_errs", 64'(s2_er), 64'(m_er));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("stat_clear", 64'(s2_rd | s2_wr | s2_er), 64'd0);
`endif
        check("queue2_drained", 64'(q2.size()), 64'd0);
        check("queue4_drained", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Memory-side responder for the core's data bus; the core-side alignment logic issues requests to it.
- Receives requests carrying addr, size, byte strobe and lane-positioned write data.
- Applies byte-strobed writes to an internal word-organised memory, or returns the full 64-bit aligned word on reads.
- Checks size/strobe/addr consistency and address range, with a configurable fixed latency.
- Used as the data memory model behind the pipeline's memory stage.

Parameters:
- DEPTH, 1024: number of 64-bit words in the memory array (power of two).
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- BASE_ADDR, 64'h8000_0000: byte address of word 0; must be DEPTH*8-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; fields held stable until data_ok
- req_addr  in  64  byte address
- req_size  in  3  msize_t: MSIZE1/2/4/8
- req_strobe  in  8  byte-lane write enables; 0 means read
- req_data  in  64  write data, already shifted to byte lanes
- resp_addr_ok  out  1  request address accepted (completion pulse)
- resp_data_ok  out  1  request complete, 1-cycle pulse
- resp_data  out  64  read word (full aligned 64 bits, unshifted); 0 on writes and on errors
- resp_err  out  1  request rejected; valid only when resp_data_ok=1

Behaviour:
- Reset: FSM -> IDLE; counter=0; resp_addr_ok=0, resp_data_ok=0, resp_data=0, resp_err=0. Memory contents are not cleared.
- Reset mid-operation: the latched request is discarded. No write occurs and no data_ok is issued.
- Word index: (req_addr - BASE_ADDR) >> 3, truncated to log2(DEPTH) bits after the range check.
- Error conditions, evaluated on latched fields:
  - addr < BASE_ADDR or addr >= BASE_ADDR + DEPTH*8.
  - addr not aligned to the size: MSIZE2 needs addr[0]=0; MSIZE4 needs addr[1:0]=0; MSIZE8 needs addr[2:0]=0.
  - Write with strobe != (mask(size) << addr[2:0]), where mask = 8'h01/8'h03/8'h0F/8'hFF. This also rejects shifted masks that overflow 8 bits.
  - req_size outside the four legal encodings.
- FSM states:
  - IDLE: if req_valid=1, latch addr/size/strobe/data and load counter=LATENCY-1. Go to RESP if LATENCY=1, else WAIT.
  - WAIT: if req_valid=0 (protocol abort), return to IDLE with no side effect. Else decrement the counter; go to RESP when it reaches 0.
  - RESP: for the one cycle in this state, resp_addr_ok=1 and resp_data_ok=1.
    - Error: no write, resp_err=1, resp_data=0.
    - Read: resp_data = mem[idx].
    - Write: mem[idx] byte k = latched data byte k wherever strobe[k]=1; other bytes unchanged; resp_data=0.
    - Next state is always IDLE.
- Latency: data_ok rises exactly LATENCY cycles after the IDLE cycle in which req_valid was first seen high.
- Back-to-back: IDLE may accept a new request in the cycle immediately after RESP. A request following a write to the same word reads the merged value.
- Outputs are registered. resp_data is held at 0 outside RESP.

Optional Feature:
- Macro: DBUS_RESP_STATS_EN.
- Defined: adds outputs stat_reads, stat_writes, stat_errs (32 bits each, out).
  - Saturating counters at 32'hFFFF_FFFF.
  - Incremented in the RESP cycle by request kind; errors count only in stat_errs.
  - Cleared by reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- LATENCY=2. Write addr=BASE+0x10, size=MSIZE8, strobe=8'hFF, data=64'h1122_3344_5566_7788 -> data_ok 2 cycles after valid, resp_err=0. A following read of the same addr returns 64'h1122_3344_5566_7788.
- Byte write: addr=BASE+0x13, MSIZE1, strobe=8'h08, data=64'h0000_0000_AB00_0000 into the word above -> read returns 64'h1122_3344_AB66_7788.
- Misaligned: read addr=BASE+0x02, MSIZE4 -> resp_err=1, resp_data=0. Write addr=BASE+0x08, MSIZE2, strobe=8'h0F -> resp_err=1, memory unchanged.
- Out of range: read addr=BASE-8, and read addr=BASE+DEPTH*8 -> each returns resp_err=1 after LATENCY cycles.
- Abort and reset: with LATENCY=4, drop req_valid in the 2nd WAIT cycle -> no data_ok. Assert reset during WAIT of a write -> all outputs 0 next cycle; a later read shows the old word.
- With DBUS_RESP_STATS_EN: 3 reads, 2 writes, 1 error -> stat_reads=3, stat_writes=2, stat_errs=1. Reset -> all 0.
